param_sequence_detector: RTL and testbench
==========================================

# param_sequence_detector

Parametrised Moore-style serial bit-pattern detector. It is the successor to the fixed 4-bit FSM detectors in the FSM library. The pattern (up to MAX_LEN bits) and its length are loaded at runtime, and overlapping or non-overlapping detection is selected per load. It sits on a serial bit stream qualified by a valid strobe and produces a registered one-cycle match pulse plus an optional saturating match counter.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
- LW, default $clog2(MAX_LEN+1): width of the length fields (derived, not overridden).
- CNT_W, default 16: match counter width.

- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- cfg_load  input  1  latch cfg_pattern, cfg_len and cfg_overlap this cycle.
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected, bit [0] the last.
- cfg_len  input  LW  pattern length; legal values are 2..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  input  1  in_bit is sampled this cycle.
- in_bit  input  1  serial data bit.
- cnt_clr  input  1  synchronous clear of match_count.
- armed  output  1  a legal configuration is held (FSM in RUN).
- cfg_err  output  1  the last cfg_load carried an illegal cfg_len.
- match  output  1  one-cycle pulse: the pattern completed on the previous accepted bit.
- match_count  output  CNT_W  saturating count of matches.

## Operation
- FSM states:
  - UNCFG (after reset): in_valid is ignored and match stays 0.
  - RUN: detecting.
- cfg_load with legal cfg_len:
  - Go to RUN.
  - Latch pattern, length and overlap mode.
  - Clear history and fill counter; cfg_err<=0.
- cfg_load with illegal cfg_len (0, 1, or >MAX_LEN):
  - Go to UNCFG.
  - cfg_err<=1; history is cleared.
- cfg_load has priority over in_valid in the same cycle; that bit is discarded.
- In RUN, on in_valid:
  - hist <= {hist[MAX_LEN-2:0], in_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Hit condition, evaluated on the post-shift window: fill_next >= len AND hist_next[len-1:0] == pattern[len-1:0]. Bits above len are masked.
- On a hit:
  - match<=1 for exactly one cycle.
  - Overlap mode: the history is retained.
  - Non-overlap mode: fill<=0, so a new match needs len fresh bits.
- match is 0 on any cycle without an accepted hitting bit, including in_valid=0 gaps. Gaps do not disturb the history.
- match_count increments on each hit and saturates at all-ones.
- cnt_clr has priority over an increment in the same cycle; the result is 0.
- cfg_load does not clear match_count.

## Timing
- Reset values: armed=0, cfg_err=0, match=0, match_count=0. The FSM is in UNCFG, history=0 and fill=0.
- Latency: the last pattern bit is sampled at edge N, and match is high in the cycle after edge N, low after edge N+1 unless hit again. The count updates at the same edge.
- Back-to-back hits on consecutive valid cycles are possible in overlap mode (e.g. pattern 11, stream 111 gives two consecutive pulses).
- A cfg_load accepted at edge N gives armed/cfg_err valid after edge N. The first countable bit is the one accepted at edge N+1.
- rst mid-stream returns to UNCFG in one edge; any pending match is dropped.

## Configuration
- PARAM_SEQ_DET_COUNT_EN defined: the match_count and cnt_clr logic is built as described.
- Not defined:
  - match_count is tied to 0 and cnt_clr is ignored.
  - No counter flops are built.
  - The ports remain, so the interface is unchanged.

## Structure
- Shared package seq_det_pkg holds the FSM state enum (UNCFG, RUN), the default MAX_LEN and CNT_W constants, and the legal-length bounds (MIN_LEN=2).
- One sub-module, seq_det_sat_counter, implements the saturating counter with clear priority. It is instantiated only under PARAM_SEQ_DET_COUNT_EN.
- History register, fill counter, masked compare and FSM live in the top module.

## Test plan
- Overlap hit: load pattern 4'b1011, len 4, overlap 1; feed 1,0,1,1,0,1,1 on consecutive cycles. match pulses after bits 4 and 7; match_count=2.
- Non-overlap: same configuration with overlap 0 and the same stream. Exactly one pulse, after bit 4; match_count=1.
- Illegal configuration and reconfiguration:
  - Load len 0: cfg_err=1, armed=0, and no match on 1011.
  - Then load pattern 3'b110, len 3: armed=1, and stream 1,1,0 gives one pulse.
- Gaps and priority:
  - Feed 1011 with in_valid low for 3 cycles between each bit: one pulse, exactly one cycle after the last valid bit.
  - Assert cfg_load on the last bit's cycle: no pulse.
- Counter edges, with CNT_W forced to 2: 4 hits give match_count 3 (saturated). cnt_clr coincident with a hit gives 0. Without PARAM_SEQ_DET_COUNT_EN, the count stays 0.
- Reset mid-pattern: feed 1,0,1, assert rst, then feed 1. No pulse, armed=0, all outputs 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised sequence detector.
package seq_det_pkg;

   typedef enum logic {
      UNCFG = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int unsigned DEF_MAX_LEN = 8;
   localparam int unsigned DEF_CNT_W   = 16;
   localparam int unsigned MIN_LEN     = 2;

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter; a clear wins over an increment in the same cycle.
module seq_det_sat_counter
#(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/param_sequence_detector.sv
// Serial bit-pattern detector with runtime-loaded pattern, length and overlap mode.
// Define PARAM_SEQ_DET_COUNT_EN to build the saturating match counter.
module param_sequence_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned LW      = $clog2(MAX_LEN + 1),
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               cnt_clr,
   output logic               armed,
   output logic               cfg_err,
   output logic               match,
   output logic [CNT_W-1:0]   match_count
);

   state_t             state, state_next;
   logic [MAX_LEN-1:0] hist, hist_next, shifted;
   logic [MAX_LEN-1:0] pat, pat_next, mask;
   logic [LW-1:0]      fill, fill_next, fill_inc;
   logic [LW-1:0]      len, len_next;
   logic               overlap, overlap_next;
   logic               err_next, match_next, len_ok, hit;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= UNCFG;
         hist    <= '0;
         fill    <= '0;
         pat     <= '0;
         len     <= '0;
         overlap <= 1'b0;
         armed   <= 1'b0;
         cfg_err <= 1'b0;
         match   <= 1'b0;
      end else begin
         state   <= state_next;
         hist    <= hist_next;
         fill    <= fill_next;
         pat     <= pat_next;
         len     <= len_next;
         overlap <= overlap_next;
         armed   <= (state_next == RUN);
         cfg_err <= err_next;
         match   <= match_next;
      end
   end

   // Next state, history shift and masked compare against the post-shift window
   always_comb begin
      state_next   = state;
      hist_next    = hist;
      fill_next    = fill;
      pat_next     = pat;
      len_next     = len;
      overlap_next = overlap;
      err_next     = cfg_err;
      match_next   = 1'b0;
      hit          = 1'b0;
      len_ok       = (cfg_len >= LW'(MIN_LEN)) && (cfg_len <= LW'(MAX_LEN));
      shifted      = {hist[MAX_LEN-2:0], in_bit};
      fill_inc     = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
      mask         = ~({MAX_LEN{1'b1}} << len);

      if (cfg_load) begin
         hist_next = '0;
         fill_next = '0;
         if (len_ok) begin
            state_next   = RUN;
            pat_next     = cfg_pattern;
            len_next     = cfg_len;
            overlap_next = cfg_overlap;
            err_next     = 1'b0;
         end else begin
            state_next = UNCFG;
            err_next   = 1'b1;
         end
      end else if ((state == RUN) && in_valid) begin
         hit        = (fill_inc >= len) && ((shifted & mask) == (pat & mask));
         hist_next  = shifted;
         // Non-overlap restarts the fill so the next match needs len fresh bits
         fill_next  = (hit && !overlap) ? '0 : fill_inc;
         match_next = hit;
      end
   end

`ifdef PARAM_SEQ_DET_COUNT_EN
   seq_det_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (match_next),
      .count (match_count)
   );
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign match_count    = '0;
`endif

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed plus random bench for param_sequence_detector against a queue-based reference model.
module tb_param_sequence_detector;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned LW      = $clog2(MAX_LEN + 1);
   localparam int unsigned CNT_W   = 2;
`ifdef PARAM_SEQ_DET_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst, cfg_load, cfg_overlap, in_valid, in_bit, cnt_clr;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LW-1:0]      cfg_len;
   logic               armed, cfg_err, match;
   logic [CNT_W-1:0]   match_count;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;

   always #5 clk = ~clk;

   param_sequence_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .cnt_clr     (cnt_clr),
      .armed       (armed),
      .cfg_err     (cfg_err),
      .match       (match),
      .match_count (match_count)
   );

   // Reference model: accepted bits since the last (re)start, newest at the back
   bit                 m_armed, m_err, m_match;
   int                 m_cnt, m_len;
   bit                 m_ovl;
   bit                 m_q[$];
   logic [MAX_LEN-1:0] m_pat;

   task automatic model_step();
      bit hit;
      hit = 1'b0;
      if (rst) begin
         m_armed = 1'b0; m_err = 1'b0; m_match = 1'b0; m_cnt = 0;
         m_q.delete();
      end else begin
         if (cfg_load) begin
            m_q.delete();
            if ((int'(cfg_len) >= 2) && (int'(cfg_len) <= int'(MAX_LEN))) begin
               m_armed = 1'b1; m_err = 1'b0;
               m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            end else begin
               m_armed = 1'b0; m_err = 1'b1;
            end
         end else if (m_armed && in_valid) begin
            m_q.push_back(in_bit);
            if (m_q.size() > int'(MAX_LEN)) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
               hit = 1'b1;
               for (int i = 0; i < m_len; i++)
                  if (m_q[m_q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
            end
            if (hit && !m_ovl) m_q.delete();
         end
         m_match = hit;
         if (COUNT_EN) begin
            if (cnt_clr) m_cnt = 0;
            else if (hit && (m_cnt < (2 ** CNT_W) - 1)) m_cnt++;
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(bit r, bit ld, logic [MAX_LEN-1:0] p, logic [LW-1:0] l, bit o,
                      bit v, bit b, bit c);
      rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      in_valid = v; in_bit = b; cnt_clr = c;
      model_step();
      @(posedge clk);
      #1;
      if (match === 1'b1) pulses++;
      chk("armed", 32'(armed), 32'(m_armed));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("match", 32'(match), 32'(m_match));
      chk("match_count", 32'(match_count), 32'(m_cnt));
   endtask

   task automatic load(logic [MAX_LEN-1:0] p, logic [LW-1:0] l, bit o);
      cyc(1'b0, 1'b1, p, l, o, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic bt(bit b);
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, b, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clr();
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic feed(logic [31:0] bits, int n);
      for (int i = n - 1; i >= 0; i--) bt(bits[i]);
   endtask

   initial begin
      logic [3:0] gbits;
      rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      in_valid = 1'b0; in_bit = 1'b0; cnt_clr = 1'b0;

      // Reset state
      cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("rst_armed", 32'(armed), 32'd0);
      chk("rst_count", 32'(match_count), 32'd0);
      bt(1'b1);
      chk("uncfg_match", 32'(match), 32'd0);

      // Overlap hit
      clr();
      load(8'b0000_1011, LW'(4), 1'b1);
      pulses = 0;
      feed(32'b1011011, 7);
      chk("ovl_pulses", 32'(pulses), 32'd2);
      chk("ovl_count", 32'(match_count), COUNT_EN ? 32'd2 : 32'd0);

      // Non-overlap
      clr();
      load(8'b0000_1011, LW'(4), 1'b0);
      pulses = 0;
      feed(32'b1011011, 7);
      chk("novl_pulses", 32'(pulses), 32'd1);
      chk("novl_count", 32'(match_count), COUNT_EN ? 32'd1 : 32'd0);

      // Illegal length then reconfigure
      load(8'b0000_1011, LW'(0), 1'b1);
      chk("bad_err", 32'(cfg_err), 32'd1);
      chk("bad_armed", 32'(armed), 32'd0);
      pulses = 0;
      feed(32'b1011, 4);
      chk("bad_pulses", 32'(pulses), 32'd0);
      load(8'b0000_1011, LW'(1), 1'b1);
      load(8'b0000_1011, LW'(9), 1'b1);
      load(8'b0000_0110, LW'(3), 1'b1);
      chk("re_armed", 32'(armed), 32'd1);
      chk("re_err", 32'(cfg_err), 32'd0);
      feed(32'b110, 3);
      chk("re_pulses", 32'(pulses), 32'd1);

      // Gaps between valid bits
      load(8'b0000_1011, LW'(4), 1'b1);
      pulses = 0;
      gbits = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
         bt(gbits[i]);
         if (i != 0) repeat (3) idle();
      end
      chk("gap_now", 32'(match), 32'd1);
      idle();
      chk("gap_after", 32'(match), 32'd0);
      chk("gap_pulses", 32'(pulses), 32'd1);

      // cfg_load wins over the completing bit
      load(8'b0000_1011, LW'(4), 1'b1);
      pulses = 0;
      feed(32'b101, 3);
      cyc(1'b0, 1'b1, 8'b0000_1011, LW'(4), 1'b1, 1'b1, 1'b1, 1'b0);
      idle();
      chk("prio_pulses", 32'(pulses), 32'd0);

      // Full-length pattern and counter saturation / clear priority
      load(8'b1001_0110, LW'(8), 1'b0);
      feed(32'b1001_0110, 8);
      clr();
      load(8'b0000_0011, LW'(2), 1'b1);
      feed(32'b11111, 5);
      chk("sat_count", 32'(match_count), COUNT_EN ? 32'd3 : 32'd0);
      cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("clr_hit_match", 32'(match), 32'd1);
      chk("clr_hit_count", 32'(match_count), 32'd0);

      // Reset mid-pattern
      load(8'b0000_1011, LW'(4), 1'b1);
      feed(32'b101, 3);
      cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      bt(1'b1);
      chk("mid_rst_armed", 32'(armed), 32'd0);
      chk("mid_rst_match", 32'(match), 32'd0);
      chk("mid_rst_err", 32'(cfg_err), 32'd0);

      // Random traffic against the model
      load(8'b0000_0101, LW'(3), 1'b1);
      for (int n = 0; n < 3000; n++) begin
         bit r, ld;
         logic [LW-1:0] l;
         r  = ($urandom_range(0, 499) == 0);
         ld = ($urandom_range(0, 59) == 0);
         case ($urandom_range(0, 9))
            0:       l = LW'($urandom_range(0, 15));
            1, 2:    l = LW'($urandom_range(2, MAX_LEN));
            default: l = LW'($urandom_range(2, 4));
         endcase
         cyc(r, ld, MAX_LEN'($urandom), l, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 39) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
